// File: rtl/adj_clk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adj_clk_pkg
// Description : Shared constants and the controller state type for the
//               adjustable tick generator (adj_tick_gen / adj_tick_core).
// Contents    : c_cnt_w          default half-period counter width
//               c_burst_w        default burst length width
//               c_default_count  half-period adopted after reset (1 Hz @ 100 MHz)
//               state_t          IDLE / RUN / BURST
// Revision    : 1.0 - initial release
// ============================================================================
package adj_clk_pkg;

    localparam int unsigned c_cnt_w         = 32;
    localparam int unsigned c_burst_w       = 8;
    localparam int unsigned c_default_count = 50_000_000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        BURST = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/adj_tick_core.sv
`default_nettype none
// ============================================================================
// Module      : adj_tick_core
// Description : Half-period counter with clk_out toggle and tick strobe.
//               Counts while i_run is high; when the count reaches
//               i_active_count-1 it wraps and clk_out toggles. tick is high
//               for the single cycle in which clk_out first reads 1.
// Ports       : clk             system clock (posedge)
//               rst_n           asynchronous active-low reset
//               i_run           count enable (controller in RUN or BURST)
//               i_clear         synchronous clear of cnt/clk_out/tick
//               i_active_count  current half-period in clock cycles (>= 1)
//               o_clk_out       divided clock (registered)
//               o_tick          one-cycle strobe on each rising clk_out
//               o_toggle        combinational: clk_out toggles at next edge
// Revision    : 1.0 - initial release
// ============================================================================
module adj_tick_core
    import adj_clk_pkg::*;
#(
    parameter int unsigned CNT_W = c_cnt_w
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_run,
    input  logic             i_clear,
    input  logic [CNT_W-1:0] i_active_count,
    output logic             o_clk_out,
    output logic             o_tick,
    output logic             o_toggle
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_clk_out;
    logic             r_tick;
    logic             w_toggle;

    // Equality-only compare: cnt never passes active_count-1, so it cannot
    // overflow. A clear always wins over a pending toggle.
    assign w_toggle = i_run & ~i_clear & (r_cnt == (i_active_count - CNT_W'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
        end else if (i_clear) begin
            r_cnt     <= '0;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
        end else if (w_toggle) begin
            r_cnt     <= '0;
            r_clk_out <= ~r_clk_out;
            // Strobe only on the 0->1 transition.
            r_tick    <= ~r_clk_out;
        end else if (i_run) begin
            r_cnt     <= r_cnt + CNT_W'(1);
            r_tick    <= 1'b0;
        end else begin
            r_tick    <= 1'b0;
        end
    end

    assign o_clk_out = r_clk_out;
    assign o_tick    = r_tick;
    assign o_toggle  = w_toggle;

endmodule
`default_nettype wire

// File: rtl/adj_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : adj_tick_gen
// Description : Programmable slow-clock / clock-enable source. Divides CLOCK
//               by a runtime-loadable half-period, in free-run or finite burst
//               mode. Period changes are shadowed and only take effect at a
//               half-period boundary (or immediately while idle).
// Ports       : CLOCK      system clock (posedge)
//               RESET_N    asynchronous active-low reset
//               en         run enable; dropping it aborts RUN/BURST
//               mode       0 = free-run, 1 = burst (sampled in IDLE only)
//               setcount   requested half-period (0 is treated as 1)
//               load       one-cycle request to adopt setcount
//               load_ack   one-cycle pulse when the new count is active
//               start      burst start (IDLE and mode = 1 only)
//               burst_len  ticks per burst, captured on start
//               clk_out    divided clock, period 2*active_count
//               tick       one-cycle strobe in the first cycle clk_out = 1
//               busy       high in RUN or BURST
//               done       one-cycle pulse on normal burst completion
// Revision    : 1.0 - initial release
// ============================================================================
module adj_tick_gen
    import adj_clk_pkg::*;
#(
    parameter int unsigned CNT_W         = c_cnt_w,
    parameter int unsigned BURST_W       = c_burst_w,
    parameter int unsigned DEFAULT_COUNT = c_default_count
) (
    input  logic               CLOCK,
    input  logic               RESET_N,
    input  logic               en,
    input  logic               mode,
    input  logic [CNT_W-1:0]   setcount,
    input  logic               load,
    output logic               load_ack,
    input  logic               start,
    input  logic [BURST_W-1:0] burst_len,
    output logic               clk_out,
    output logic               tick,
    output logic               busy,
    output logic               done
);

    state_t             r_state;
    logic [CNT_W-1:0]   r_active_count;
    logic [CNT_W-1:0]   r_pending_count;
    logic               r_pending_flag;
    logic [BURST_W-1:0] r_tick_cnt;
    logic [BURST_W-1:0] r_burst_len;

    logic               w_toggle;
    logic               w_running;
    logic               w_abort;
    logic               w_zero_burst;
    logic               w_burst_end;
    logic               w_clear;
    logic               w_apply;
    logic [CNT_W-1:0]   w_setcount_clamped;

    assign w_running    = (r_state != IDLE);
    assign w_abort      = w_running & ~en;
    assign w_zero_burst = (r_state == BURST) & (r_burst_len == '0);
    // The falling toggle after the last tick ends the burst; clk_out drops
    // at that same edge, so the final low phase is not stretched.
    assign w_burst_end  = (r_state == BURST) & w_toggle & clk_out &
                          (r_tick_cnt == r_burst_len);
    assign w_clear      = ~w_running | w_abort | w_zero_burst;

    // Only a load registered in an earlier cycle can be applied; a load that
    // coincides with a toggle waits for the following toggle.
    assign w_apply = r_pending_flag & (~w_running | w_toggle);

    assign w_setcount_clamped = (setcount == '0) ? CNT_W'(1) : setcount;

    adj_tick_core #(
        .CNT_W (CNT_W)
    ) u_core (
        .clk            (CLOCK),
        .rst_n          (RESET_N),
        .i_run          (w_running),
        .i_clear        (w_clear),
        .i_active_count (r_active_count),
        .o_clk_out      (clk_out),
        .o_tick         (tick),
        .o_toggle       (w_toggle)
    );

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state         <= IDLE;
            r_active_count  <= CNT_W'(DEFAULT_COUNT);
            r_pending_count <= '0;
            r_pending_flag  <= 1'b0;
            r_tick_cnt      <= '0;
            r_burst_len     <= '0;
            load_ack        <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            load_ack <= 1'b0;
            done     <= 1'b0;

            if (w_apply) begin
                r_active_count <= r_pending_count;
                r_pending_flag <= 1'b0;
                load_ack       <= 1'b1;
            end
            // A new request overrides both the old pending value and a
            // same-cycle apply clearing the flag.
            if (load) begin
                r_pending_count <= w_setcount_clamped;
                r_pending_flag  <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (en && !mode) begin
                        r_state <= RUN;
                        busy    <= 1'b1;
                    end else if (en && mode && start) begin
                        r_state     <= BURST;
                        busy        <= 1'b1;
                        r_tick_cnt  <= '0;
                        r_burst_len <= burst_len;
                    end
                end
                RUN: begin
                    if (w_abort) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                BURST: begin
                    if (w_abort) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end else if (w_zero_burst || w_burst_end) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else if (w_toggle && !clk_out) begin
                        r_tick_cnt <= r_tick_cnt + BURST_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
